// File: rtl/spinnaker_fpgas_reg_bus_pkg.sv
// Shared types and constants for the SPI-side register-bus arbiter.
// Imported by the arbiter top and its round-robin grant sub-module.
package spinnaker_fpgas_reg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        DONE
    } state_e;

    localparam int SPI_REQ  = 0;
    localparam int HK_REQ   = 1;
    localparam int LAT_BITS = 4;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spinnaker_fpgas_reg_bus_arbiter_if.sv
// Requester-side and decoder-side signals of the shared register bus.
// master = the arbiter; slave = requesters plus address decoder.
interface spinnaker_fpgas_reg_bus_arbiter_if #(
    parameter int ADDR_BITS = 32,
    parameter int VAL_BITS  = 32
);
    logic [1:0]             REQ_IN;
    logic [1:0]             REQ_WRITE_IN;
    logic [2*ADDR_BITS-1:0] REQ_ADDR_IN;
    logic [2*VAL_BITS-1:0]  REQ_WRITE_VALUE_IN;
    logic [1:0]             ACK_OUT;
    logic [VAL_BITS-1:0]    READ_VALUE_OUT;
    logic [ADDR_BITS-1:0]   BUS_ADDR_OUT;
    logic [VAL_BITS-1:0]    BUS_WRITE_VALUE_OUT;
    logic                   BUS_READ_OUT;
    logic                   BUS_WRITE_OUT;
    logic [VAL_BITS-1:0]    BUS_READ_VALUE_IN;
    logic                   BUSY_OUT;

    modport master (
        input  REQ_IN, REQ_WRITE_IN, REQ_ADDR_IN, REQ_WRITE_VALUE_IN,
        input  BUS_READ_VALUE_IN,
        output ACK_OUT, READ_VALUE_OUT, BUS_ADDR_OUT, BUS_WRITE_VALUE_OUT,
        output BUS_READ_OUT, BUS_WRITE_OUT, BUSY_OUT
    );

    modport slave (
        output REQ_IN, REQ_WRITE_IN, REQ_ADDR_IN, REQ_WRITE_VALUE_IN,
        output BUS_READ_VALUE_IN,
        input  ACK_OUT, READ_VALUE_OUT, BUS_ADDR_OUT, BUS_WRITE_VALUE_OUT,
        input  BUS_READ_OUT, BUS_WRITE_OUT, BUSY_OUT
    );

endinterface

// File: rtl/spinnaker_fpgas_rr_arbiter2.sv
// Two-input round-robin grant: on a tie the port that did not win last time wins.
// last-grant resets to the housekeeping port so the SPI port wins the first tie.
module spinnaker_fpgas_rr_arbiter2
    import spinnaker_fpgas_reg_bus_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_grant,
    output logic       o_valid
);

    logic r_last;
    logic w_grant;

    always_comb begin
        w_grant = 1'(SPI_REQ);
        if (i_req[HK_REQ] && (!i_req[SPI_REQ] || r_last == 1'(SPI_REQ)))
            w_grant = 1'(HK_REQ);
    end

    assign o_grant = w_grant;
    assign o_valid = |i_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_last <= 1'(HK_REQ);
        else if (i_en && o_valid)
            r_last <= w_grant;
    end

endmodule

// File: rtl/spinnaker_fpgas_reg_bus_arbiter.sv
// Shares the SPI register bus between the SPI slave and the housekeeping poller.
// One access at a time: grant, one-cycle strobe, fixed read wait, one-cycle ack.
module spinnaker_fpgas_reg_bus_arbiter
    import spinnaker_fpgas_reg_bus_pkg::*;
#(
    parameter int ADDR_BITS    = 32,
    parameter int VAL_BITS     = 32,
    parameter int READ_LATENCY = 1
) (
    input logic CLK_IN,
    input logic RESET_IN,
    spinnaker_fpgas_reg_bus_arbiter_if.master bus
);

    localparam logic [LAT_BITS-1:0] LAT = LAT_BITS'(READ_LATENCY);
    localparam logic [LAT_BITS-1:0] ONE = LAT_BITS'(1);

    state_e               r_state, w_state_nxt;
    logic                 r_port, w_port_nxt;
    logic                 r_wr, w_wr_nxt;
    logic [LAT_BITS-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]           r_ack, w_ack_nxt;
    logic [VAL_BITS-1:0]  r_rv, w_rv_nxt;
    logic [ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [VAL_BITS-1:0]  r_wv, w_wv_nxt;
    logic                 r_bus_rd, w_bus_rd_nxt;
    logic                 r_bus_wr, w_bus_wr_nxt;
    logic                 r_busy;
    logic                 w_gnt, w_gnt_vld, w_gnt_en;

    assign w_gnt_en = (r_state == IDLE);

    spinnaker_fpgas_rr_arbiter2 u_rr (
        .i_clk   (CLK_IN),
        .i_rst   (RESET_IN),
        .i_req   (bus.REQ_IN),
        .i_en    (w_gnt_en),
        .o_grant (w_gnt),
        .o_valid (w_gnt_vld)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_port_nxt   = r_port;
        w_wr_nxt     = r_wr;
        w_cnt_nxt    = r_cnt;
        w_ack_nxt    = 2'b00;
        w_rv_nxt     = r_rv;
        w_addr_nxt   = r_addr;
        w_wv_nxt     = r_wv;
        w_bus_rd_nxt = 1'b0;
        w_bus_wr_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_port_nxt   = w_gnt;
                    w_wr_nxt     = bus.REQ_WRITE_IN[w_gnt];
                    w_addr_nxt   = w_gnt ? bus.REQ_ADDR_IN[2*ADDR_BITS-1:ADDR_BITS]
                                         : bus.REQ_ADDR_IN[ADDR_BITS-1:0];
                    w_wv_nxt     = w_gnt ? bus.REQ_WRITE_VALUE_IN[2*VAL_BITS-1:VAL_BITS]
                                         : bus.REQ_WRITE_VALUE_IN[VAL_BITS-1:0];
                    w_bus_wr_nxt = w_wr_nxt;
                    w_bus_rd_nxt = !w_wr_nxt;
                    w_state_nxt  = STROBE;
                end
            end
            STROBE: begin
                if (r_wr) begin
                    w_ack_nxt   = port_onehot(r_port);
                    w_state_nxt = DONE;
                end else if (LAT == '0) begin
                    w_rv_nxt    = bus.BUS_READ_VALUE_IN;
                    w_ack_nxt   = port_onehot(r_port);
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = LAT;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Decoder data is valid in the last wait cycle.
                if (r_cnt == ONE) begin
                    w_rv_nxt    = bus.BUS_READ_VALUE_IN;
                    w_ack_nxt   = port_onehot(r_port);
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt - ONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            r_state  <= IDLE;
            r_port   <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= '0;
            r_ack    <= 2'b00;
            r_rv     <= '0;
            r_addr   <= '0;
            r_wv     <= '0;
            r_bus_rd <= 1'b0;
            r_bus_wr <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_port   <= w_port_nxt;
            r_wr     <= w_wr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack    <= w_ack_nxt;
            r_rv     <= w_rv_nxt;
            r_addr   <= w_addr_nxt;
            r_wv     <= w_wv_nxt;
            r_bus_rd <= w_bus_rd_nxt;
            r_bus_wr <= w_bus_wr_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign bus.ACK_OUT             = r_ack;
    assign bus.READ_VALUE_OUT      = r_rv;
    assign bus.BUS_ADDR_OUT        = r_addr;
    assign bus.BUS_WRITE_VALUE_OUT = r_wv;
    assign bus.BUS_READ_OUT        = r_bus_rd;
    assign bus.BUS_WRITE_OUT       = r_bus_wr;
    assign bus.BUSY_OUT            = r_busy;

endmodule

// File: doc/spinnaker_fpgas_reg_bus_arbiter.md
Name: spinnaker_fpgas_reg_bus_arbiter

Overview:
Shares the single SPI-side register bus (address, read/write strobes, read-value return) between two requesters: the SPI slave (port 0) and the on-chip housekeeping poller (port 1). Sits between the requesters and the SPI address decoder. Serialises accesses into one-cycle strobes, waits a fixed read latency, latches the returned value and acknowledges the winner. Uses round-robin arbitration so neither requester starves.

Parameters:
ADDR_BITS, 32, request/bus address width.
VAL_BITS, 32, data word width.
READ_LATENCY, 1, cycles from strobe cycle to valid BUS_READ_VALUE_IN; legal range 0..15.

Ports:
CLK_IN  in  1  single clock.
RESET_IN  in  1  asynchronous, active-high reset.
REQ_IN  in  2  per-requester request; held until ACK.
REQ_WRITE_IN  in  2  per requester: 1 = write, 0 = read.
REQ_ADDR_IN  in  2*ADDR_BITS  per-requester address; requester n uses slice n.
REQ_WRITE_VALUE_IN  in  2*VAL_BITS  per-requester write data.
ACK_OUT  out  2  one-cycle completion pulse per requester.
READ_VALUE_OUT  out  VAL_BITS  read data; valid in the ACK cycle, held until the next read completes.
BUS_ADDR_OUT  out  ADDR_BITS  address to decoder.
BUS_WRITE_VALUE_OUT  out  VAL_BITS  write data to decoder.
BUS_READ_OUT  out  1  read strobe.
BUS_WRITE_OUT  out  1  write strobe.
BUS_READ_VALUE_IN  in  VAL_BITS  value from decoder.
BUSY_OUT  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; ACK_OUT=0; BUS_READ_OUT=0; BUS_WRITE_OUT=0; BUS_ADDR_OUT=0; BUS_WRITE_VALUE_OUT=0; READ_VALUE_OUT=0; BUSY_OUT=0; last_grant=1, so port 0 wins the first tie.
- All other state changes occur on the rising edge of CLK_IN. All outputs are registered.
- IDLE: if any REQ_IN bit is set, pick the grant.
  - One request: grant that port.
  - Both requests: grant the port not equal to last_grant.
  - On grant: latch the port's address, write flag and write data onto the BUS_* registers; set last_grant; go to STROBE.
- STROBE (exactly 1 cycle): assert BUS_WRITE_OUT or BUS_READ_OUT according to the latched write flag. The other strobe stays 0. Never both.
  - Write: go to DONE.
  - Read with READ_LATENCY=0: capture BUS_READ_VALUE_IN this cycle; go to DONE.
  - Read with READ_LATENCY>0: load the counter with READ_LATENCY; go to WAIT.
- WAIT: strobes are low; BUS_ADDR_OUT stays stable. Decrement the counter each cycle. In the cycle the counter equals 1, capture BUS_READ_VALUE_IN into READ_VALUE_OUT; go to DONE.
- DONE (1 cycle): pulse ACK_OUT[grant]; return to IDLE.
  - The next grant is evaluated in the following IDLE cycle. A new request is not granted in the DONE cycle.
- Latency, REQ_IN rise to ACK_OUT:
  - Write: 3 cycles.
  - Read: 3 + READ_LATENCY cycles.
  - Minimum spacing between strobes: 3 + READ_LATENCY cycles for reads, 3 for writes.
- Boundary conditions:
  - REQ_IN dropped mid-transaction: the transaction still completes and ACK is still pulsed. A requester must not drop REQ_IN and raise it again within the same transaction.
  - REQ_IN held high after ACK: treated as a new request in the next IDLE cycle. Continuous requests from both ports alternate 0,1,0,1.
  - Request inputs change after grant: no effect until the next grant; the latched copies are used.
  - Writes do not modify READ_VALUE_OUT.
  - RESET_IN asserted mid-transaction: the strobe drops immediately and no ACK is produced. After release the arbiter is in IDLE with last_grant=1.

Decomposition:
- Shared package (spinnaker_fpgas_reg_bus_pkg):
  - State encodings: IDLE, STROBE, WAIT, DONE.
  - Requester index constants: SPI_REQ=0, HK_REQ=1.
  - Latency counter width: 4.
- Sub-module spinnaker_fpgas_rr_arbiter2: two-input round-robin grant logic with a last_grant register and a grant-enable input. The FSM and datapath registers stay in the top module.

Test Plan:
1. Reset, then port 0 writes addr 32'h0002_0010, data 32'hDEAD_BEEF → BUS_WRITE_OUT high for exactly 1 cycle with that address and data; ACK_OUT=2'b01 three cycles after REQ_IN; READ_VALUE_OUT stays 0.
2. READ_LATENCY=1, port 1 reads addr 32'h0003_0004; bench drives BUS_READ_VALUE_IN=32'h1234_5678 one cycle after the strobe → ACK_OUT=2'b10 at cycle 4 and READ_VALUE_OUT=32'h1234_5678 in the ACK cycle.
3. Both ports request reads continuously for 6 transactions → grant order 0,1,0,1,0,1; exactly one strobe per transaction; no cycle with both strobes high.
4. Port 0 drops REQ_IN during WAIT → ACK_OUT[0] still pulses; next IDLE grants port 1 if it is requesting, otherwise the arbiter stays IDLE.
5. Assert RESET_IN during STROBE of a write → BUS_WRITE_OUT falls before the next clock edge and no ACK is issued; after release, both ports requesting simultaneously → port 0 granted first.
6. READ_LATENCY=0 build: read from addr 32'h0004_0000 with BUS_READ_VALUE_IN=32'hA5A5_0001 during the strobe cycle → ACK at cycle 3 with READ_VALUE_OUT=32'hA5A5_0001.
